// File: rtl/fp_seq_ctrl.sv
// Sequencer for a multi-cycle FPU beside the integer pipe: it issues the op,
// counts the execute latency, arbitrates the shared RF write port and
// raises hazard stalls.
module fp_seq_ctrl #(
  parameter int REG_WIDTH  = 4,
  parameter int FP_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fp_issue_i,
  input  logic [REG_WIDTH-1:0] fp_rd_i,
  input  logic                 flush_i,
  input  logic                 id_floating_i,
  input  logic                 id_regwrite_i,
  input  logic [REG_WIDTH-1:0] rsD_i,
  input  logic [REG_WIDTH-1:0] rtD_i,
  input  logic [REG_WIDTH-1:0] rdD_i,
  input  logic                 int_wb_i,
  output logic                 fpu_start_o,
  output logic                 stall_o,
  output logic                 fp_wb_en_o,
  output logic [REG_WIDTH-1:0] fp_wb_rd_o,
  output logic                 int_wb_hold_o,
  output logic                 busy_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam int            CW       = 3;
  localparam logic [CW-1:0] CNT_INIT = CW'(FP_LATENCY - 1);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [1:0]           deny_cnt;
  logic [REG_WIDTH-1:0] pend_rd;
  logic                 err_q;
  logic                 accept, grant, raw, waw;

  assign accept = (state == IDLE) && fp_issue_i && !flush_i;
  // Integer writeback wins the port at most twice in a row, then the FP result is forced through.
  assign grant  = (state == WB) && !((deny_cnt < 2'd2) && int_wb_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      deny_cnt <= '0;
      pend_rd  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        pend_rd <= fp_rd_i;
        cnt     <= CNT_INIT;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == WB) deny_cnt <= grant ? 2'd0 : deny_cnt + 2'd1;
      if (fp_issue_i && state != IDLE) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = WB;
      WB:      if (grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    raw           = (rsD_i == pend_rd) || (rtD_i == pend_rd);
    waw           = id_regwrite_i && (rdD_i == pend_rd);
    busy_o        = (state != IDLE);
    fpu_start_o   = (state == EXEC) && (cnt == CNT_INIT);
    fp_wb_en_o    = grant;
    fp_wb_rd_o    = grant ? pend_rd : '0;
    int_wb_hold_o = grant && int_wb_i;
    // RAW is covered by same-cycle RF forwarding once the FP result is being written.
    stall_o       = busy_o && (id_floating_i || (raw && !grant) || waw);
    err_o         = err_q;
  end

endmodule

// File: tb/tb_fp_seq_ctrl.sv
// Scoreboard bench for fp_seq_ctrl: a per-cycle stimulus table (directed
// prefix, random body) feeds a timeline model; a negedge monitor checks.
module tb_fp_seq_ctrl;
  localparam int RW   = 4;
  localparam int L    = 4;
  localparam int NCYC = 2000;
  localparam int TAIL = 16;
  localparam int DIR  = 28;

  logic clk = 1'b0;
  logic rst, fp_issue_i, flush_i, id_floating_i, id_regwrite_i, int_wb_i;
  logic [RW-1:0] fp_rd_i, rsD_i, rtD_i, rdD_i, fp_wb_rd_o;
  logic fpu_start_o, stall_o, fp_wb_en_o, int_wb_hold_o, busy_o, err_o;

  always #5 clk = ~clk;

  fp_seq_ctrl #(.REG_WIDTH(RW), .FP_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .fp_issue_i(fp_issue_i), .fp_rd_i(fp_rd_i),
    .flush_i(flush_i), .id_floating_i(id_floating_i), .id_regwrite_i(id_regwrite_i),
    .rsD_i(rsD_i), .rtD_i(rtD_i), .rdD_i(rdD_i), .int_wb_i(int_wb_i),
    .fpu_start_o(fpu_start_o), .stall_o(stall_o), .fp_wb_en_o(fp_wb_en_o),
    .fp_wb_rd_o(fp_wb_rd_o), .int_wb_hold_o(int_wb_hold_o), .busy_o(busy_o),
    .err_o(err_o)
  );

  typedef struct {
    logic rst, issue, flush, intwb, idf, regw;
    logic [RW-1:0] rd, rs, rt, rdd;
  } stim_t;

  typedef struct {
    int cyc;
    logic [RW-1:0] rd;
    logic hold;
  } wb_t;

  stim_t st[NCYC+8];
  wb_t   q[$];
  int    tests = 0, fails = 0, cur = -1;
  logic  exp_busy, exp_start, exp_stall, exp_err;
  bit    done = 0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cur, act, exp);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s.rst = 0; s.issue = 0; s.flush = 0; s.intwb = 0; s.idf = 0; s.regw = 0;
    s.rd = '0; s.rs = '0; s.rt = '0; s.rdd = '0;
    return s;
  endfunction

  function automatic stim_t rnd_s(int n);
    stim_t s;
    bit body = (n < NCYC - TAIL);
    s.rst   = body && ($urandom_range(63) == 0);
    s.issue = body && ($urandom_range(2) == 0);
    s.flush = ($urandom_range(3) == 0);
    s.intwb = $urandom_range(1);
    s.idf   = ($urandom_range(4) == 0);
    s.regw  = $urandom_range(1);
    s.rd    = RW'($urandom_range(7));
    s.rs    = RW'($urandom_range(7));
    s.rt    = RW'($urandom_range(7));
    s.rdd   = RW'($urandom_range(7));
    return s;
  endfunction

  // Stimulus table: directed scenarios first, then random traffic, then an idle tail.
  initial begin
    for (int n = 0; n < NCYC + 8; n++) st[n] = (n >= DIR && n < NCYC) ? rnd_s(n) : idle_s();
    st[0].rst = 1; st[1].rst = 1;
    st[2].issue = 1; st[2].rd = 4'd5;                       // plain latency, no contention
    st[8].issue = 1; st[8].rd = 4'd3;                       // contended writeback
    st[13].intwb = 1; st[14].intwb = 1; st[15].intwb = 1;
    st[9].rt = 4'd3;                                        // RAW
    st[10].rs = 4'd7; st[10].rt = 4'd7; st[10].rdd = 4'd7; st[10].regw = 1;
    st[11].rs = 4'd7; st[11].rt = 4'd7; st[11].rdd = 4'd7; st[11].idf = 1;
    st[12].issue = 1; st[12].rd = 4'd6;                     // issue while busy
    st[15].issue = 1; st[15].rd = 4'd4;                     // issue on grant cycle
    st[16].issue = 1; st[16].flush = 1; st[16].rd = 4'd8;   // flushed issue
    st[18].issue = 1; st[18].rd = 4'd9;
    st[20].rst = 1;                                         // reset in 2nd EXEC cycle
    st[21].issue = 1; st[21].rd = 4'd2;
  end

  // Driver plus reference model: each accepted op occupies a window of cycles
  // [n+1, g], where g is the first cycle from n+L+1 on with no integer write,
  // capped at two denials.
  initial begin
    int bf, fa, g, w;
    logic err_m, busy;
    logic [RW-1:0] prd;
    stim_t s;
    bf = 0; fa = 0; g = -1; err_m = 0; prd = '0;
    rst = 1; fp_issue_i = 0; flush_i = 0; id_floating_i = 0; id_regwrite_i = 0;
    int_wb_i = 0; fp_rd_i = '0; rsD_i = '0; rtD_i = '0; rdD_i = '0;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      s = st[n];
      rst = s.rst; fp_issue_i = s.issue; flush_i = s.flush; int_wb_i = s.intwb;
      id_floating_i = s.idf; id_regwrite_i = s.regw; fp_rd_i = s.rd;
      rsD_i = s.rs; rtD_i = s.rt; rdD_i = s.rdd;
      if (s.rst) begin
        q.delete();
        bf = 0; fa = 0; g = -1; err_m = 0; prd = '0;
        exp_busy = 0; exp_start = 0; exp_stall = 0; exp_err = 0;
      end else begin
        busy      = (n >= bf) && (n < fa);
        exp_busy  = busy;
        exp_start = busy && (n == bf);
        exp_err   = err_m;
        exp_stall = busy && (s.idf || (((s.rs == prd) || (s.rt == prd)) && n != g) ||
                             (s.regw && s.rdd == prd));
        if (s.issue && busy) err_m = 1;
        if (s.issue && !s.flush && !busy) begin
          w  = n + L + 1;
          g  = !st[w].intwb ? w : (!st[w+1].intwb ? w + 1 : w + 2);
          bf = n + 1;
          fa = g + 1;
          prd = s.rd;
          q.push_back('{cyc: g, rd: s.rd, hold: st[g].intwb});
        end
      end
      cur = n;
    end
    @(posedge clk);
    done = 1;
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: level checks every cycle, writeback pulses matched against the queue.
  always @(negedge clk) begin
    if (cur >= 0 && !done) begin
      chk("busy", busy_o, exp_busy);
      chk("fpu_start", fpu_start_o, exp_start);
      chk("stall", stall_o, exp_stall);
      chk("err", err_o, exp_err);
      if (fp_wb_en_o) begin
        if (q.size() == 0) chk("wb_en_spurious", fp_wb_en_o, 0);
        else begin
          wb_t e;
          e = q.pop_front();
          chk("wb_cycle", cur, e.cyc);
          chk("wb_rd", fp_wb_rd_o, e.rd);
          chk("wb_hold", int_wb_hold_o, e.hold);
        end
      end else begin
        chk("wb_rd_idle", fp_wb_rd_o, 0);
        chk("wb_hold_idle", int_wb_hold_o, 0);
        if (q.size() > 0 && q[0].cyc <= cur) begin
          chk("wb_en_missing", fp_wb_en_o, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #((NCYC + 100) * 10);
    $display("FAIL timeout cycle=%0d actual=running expected=finished", cur);
    $fatal(1, "timeout");
  end

endmodule
